// File: rtl/sender_msg_streamer_pkg.sv
// sender_msg_streamer_pkg: shared state, data types and configuration check for the message streamer
package sender_msg_streamer_pkg;
  typedef enum logic [2:0] {IDLE, WAIT, FETCH, DRAIN, DONE} state_t;
  typedef logic [127:0] block_t;
  function automatic bit cfg_ok(input int depth, input int lat);
    return lat >= 0 && lat <= 4 && depth >= lat + 1 && (depth & (depth - 1)) == 0;
  endfunction
endpackage

// File: rtl/sender_msg_streamer_fifo.sv
// msg_stream_fifo: first-word-fall-through synchronous FIFO carrying a message plus its last flag
module msg_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 129,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [W-1:0]  wdata,
  input  logic          rd,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_wr, do_rd;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign rdata = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_wr) wp <= inc(wp);
      if (do_rd) rp <= inc(rp);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  always_ff @(posedge clk)
    if (do_wr) mem[wp] <= wdata;
endmodule

// File: rtl/sender_msg_streamer.sv
// sender_msg_streamer: sweeps cluster messages into a credit-controlled valid/ready stream; MSG_STREAM_CHECKSUM_EN adds m_checksum
module sender_msg_streamer
  import sender_msg_streamer_pkg::*;
#(
  parameter int MSG_NUM = 8,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cluster_done,
  output logic [IDX_W-1:0] msg_index,
  input  logic [127:0]     msg_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [127:0]     m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done
`ifdef MSG_STREAM_CHECKSUM_EN
  ,
  output logic [127:0]     m_checksum
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  state_t state, nxt;
  logic [IDX_W-1:0] idx;
  logic [CW-1:0] cnt;
  logic [2:0] infl;
  logic [128:0] head;
  logic full, empty, issue, last_idx, hs, wr, wl;
  if (!cfg_ok(FIFO_DEPTH, READ_LATENCY) || MSG_NUM < 1) begin : g_bad_cfg
    $error("sender_msg_streamer: invalid MSG_NUM/READ_LATENCY/FIFO_DEPTH");
  end
  assign last_idx = idx == IDX_W'(MSG_NUM - 1);
  assign issue = state == FETCH && int'(cnt) + int'(infl) < FIFO_DEPTH;
  assign hs = !empty && m_ready;
  always_ff @(posedge clk)
    state <= !rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? WAIT : IDLE;
      WAIT:    nxt = cluster_done ? FETCH : WAIT;
      FETCH:   nxt = issue && last_idx ? DRAIN : FETCH;
      DRAIN:   nxt = hs && head[128] && infl == '0 && cnt == CW'(1) ? DONE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst || state == IDLE || state == DONE) idx <= '0;
    else if (issue && !last_idx) idx <= idx + 1'b1;
  // valid/last travel alongside the cluster read so each message is captured when it matures
  if (READ_LATENCY > 0) begin : g_pipe
    logic [READ_LATENCY-1:0] pv, pl;
    always_ff @(posedge clk)
      if (!rst) begin
        pv <= '0;
        pl <= '0;
      end else begin
        pv <= READ_LATENCY'({pv, issue});
        pl <= READ_LATENCY'({pl, issue && last_idx});
      end
    assign wr = pv[READ_LATENCY-1];
    assign wl = pl[READ_LATENCY-1];
    assign infl = 3'($countones(pv));
  end else begin : g_direct
    assign wr = issue;
    assign wl = last_idx;
    assign infl = '0;
  end
  msg_stream_fifo #(.DEPTH(FIFO_DEPTH), .W(129)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr(wr),
    .wdata({wl, msg_in}),
    .rd(hs),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(cnt)
  );
  always_ff @(posedge clk)
    if (rst && wr) assert (!full || hs);
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
    msg_index = idx;
    m_valid = !empty;
    m_data = head[127:0];
    m_last = head[128];
  end
`ifdef MSG_STREAM_CHECKSUM_EN
  always_ff @(posedge clk)
    if (!rst || (state == WAIT && cluster_done)) m_checksum <= '0;
    else if (hs) m_checksum <= m_checksum ^ head[127:0];
`endif
endmodule

// File: tb/tb_sender_msg_streamer.sv
// tb_sender_msg_streamer: three read-latency variants driven in lockstep and checked against a beat-level model
module tb_sender_msg_streamer;
  logic clk = 0, rst = 0, start = 0, cluster_done = 0, m_ready = 1, bp = 0, mode = 0;
  logic [31:0] msg_index [3];
  logic [127:0] msg_in [3], m_data [3];
  logic m_valid [3], m_last [3], busy [3], done [3];
`ifdef MSG_STREAM_CHECKSUM_EN
  logic [127:0] m_checksum [3];
`endif
  int errors = 0, checks = 0;
  int k_cnt [3], sweeps [3], maxgap [3];
  logic [127:0] basic_exp [8] = '{128'h0, 128'h1111, 128'h2222, 128'h3333,
                                  128'h4444, 128'h5555, 128'h6666, 128'h7777};
  always #5 clk = ~clk;
  function automatic logic [127:0] f(input logic m, input logic [31:0] x);
    return m ? 128'(x) + 128'd1 : 128'(x) * 128'h1111;
  endfunction
  task automatic chk(input int g, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s: got %0h expected %0h", g, name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_sweeps(input int target);
    int n = 0;
    while ((sweeps[0] < target || sweeps[1] < target || sweeps[2] < target) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(0, "sweep_timeout", sweeps[0] >= target && sweeps[1] >= target && sweeps[2] >= target, 1);
  endtask
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = g == 0 ? 1 : g == 1 ? 0 : 3;
    logic [31:0] hist [4];
    logic rst_q = 1'b0, hold = 1'b0, hold_l = 1'b0, done_due = 1'b0;
    logic [127:0] hold_d = '0, cs = '0;
    int gap;
    sender_msg_streamer #(.MSG_NUM(8), .READ_LATENCY(L), .FIFO_DEPTH(4), .IDX_W(32)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .cluster_done(cluster_done),
      .msg_index(msg_index[g]),
      .msg_in(msg_in[g]),
      .m_valid(m_valid[g]),
      .m_ready(m_ready),
      .m_data(m_data[g]),
      .m_last(m_last[g]),
      .busy(busy[g]),
`ifdef MSG_STREAM_CHECKSUM_EN
      .m_checksum(m_checksum[g]),
`endif
      .done(done[g])
    );
    assign msg_in[g] = f(mode, L == 0 ? msg_index[g] : hist[L > 0 ? L - 1 : 0]);
    always @(posedge clk) begin
      rst_q <= rst;
      hist[0] <= msg_index[g];
      for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
    end
    always @(negedge clk) begin
      if (!rst_q) begin
        chk(g, "reset_valid", m_valid[g], 0);
        chk(g, "reset_busy", busy[g], 0);
        chk(g, "reset_done", done[g], 0);
        chk(g, "reset_index", msg_index[g], 0);
        chk(g, "reset_data", m_data[g], 0);
        chk(g, "reset_last", m_last[g], 0);
        k_cnt[g] = 0;
        hold = 0;
        done_due = 0;
        cs = '0;
      end else begin
        gap = int'(msg_index[g]) - k_cnt[g];
        if (gap > maxgap[g]) maxgap[g] = gap;
        chk(g, "credit_limit", gap > 4, 0);
        chk(g, "index_range", msg_index[g] <= 7, 1);
        if (done_due) begin
          chk(g, "done_pulse", done[g], 1);
`ifdef MSG_STREAM_CHECKSUM_EN
          chk(g, "checksum", m_checksum[g], cs);
`endif
          sweeps[g]++;
          k_cnt[g] = 0;
          cs = '0;
          done_due = 0;
        end else chk(g, "done_low", done[g], 0);
        if (m_valid[g]) begin
          if (hold) begin
            chk(g, "hold_data", m_data[g], hold_d);
            chk(g, "hold_last", m_last[g], hold_l);
          end
          chk(g, "beat_count", k_cnt[g] < 8, 1);
          chk(g, "beat_data", m_data[g], f(mode, 32'(k_cnt[g])));
          chk(g, "beat_last", m_last[g], k_cnt[g] == 7);
          if (m_ready) begin
            cs ^= f(mode, 32'(k_cnt[g]));
            k_cnt[g]++;
            done_due = k_cnt[g] == 8;
          end
        end
        hold = m_valid[g] && !m_ready;
        hold_d = m_data[g];
        hold_l = m_last[g];
      end
    end
  end
  initial begin
    int c = 0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = bp ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
      c++;
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk(g, "lit_reset_index", msg_index[g], 0);
      chk(g, "lit_reset_valid", m_valid[g], 0);
      chk(g, "lit_reset_busy", busy[g], 0);
    end
    step; rst = 1;
    step; start = 1;
    step; start = 0; cluster_done = 1;
    begin
      int n = 0;
      while (!m_valid[0] && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk(0, "basic_first_valid", m_valid[0], 1);
    for (int i = 0; i < 8; i++) begin
      chk(0, "basic_valid", m_valid[0], 1);
      chk(0, "basic_data", m_data[0], basic_exp[i]);
      chk(0, "basic_last", m_last[0], i == 7);
      @(negedge clk);
    end
    chk(0, "basic_done", done[0], 1);
    chk(0, "basic_after_valid", m_valid[0], 0);
    wait_sweeps(1);
    step; cluster_done = 0;
    maxgap = '{0, 0, 0};
    bp = 1; start = 1; cluster_done = 1;
    step; start = 0;
    step; cluster_done = 0;
    wait_sweeps(2);
    chk(0, "bp_stall_depth", maxgap[0], 4);
    bp = 0;
    step; start = 1;
    step; start = 0;
    repeat (20) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        chk(g, "gated_busy", busy[g], 1);
        chk(g, "gated_index", msg_index[g], 0);
        chk(g, "gated_valid", m_valid[g], 0);
      end
    end
    step; cluster_done = 1;
    wait_sweeps(3);
    step; start = 1;
    step; start = 0;
    begin
      int n = 0;
      while (k_cnt[0] < 3 && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk(0, "mid_three_beats", k_cnt[0] >= 3, 1);
    step; rst = 0;
    @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk(g, "mid_reset_valid", m_valid[g], 0);
      chk(g, "mid_reset_busy", busy[g], 0);
      chk(g, "mid_reset_index", msg_index[g], 0);
    end
    step; rst = 1;
    step; start = 1;
    step; start = 0;
    wait_sweeps(4);
    step; cluster_done = 0; mode = 1;
    step; start = 1; cluster_done = 1;
    step; start = 0;
    wait_sweeps(5);
`ifdef MSG_STREAM_CHECKSUM_EN
    chk(0, "checksum_literal", m_checksum[0], 128'h8);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
